// File: rtl/result_uart_dumper.sv
// Streams LENGTH bytes from data memory out of an 8N1 UART after a matrix run.
// busy/done are registered, so done arrives the cycle after FIN, as busy falls.
module result_uart_dumper #(
  parameter int CLKS_PER_BIT = 434,
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [15:0] length,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_q,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [15:0] byte_cnt
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_STOP, S_FIN
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [BAUD_W-1:0]   r_baud;
  logic [1:0]          r_lat;
  logic [2:0]          r_bit;
  logic [7:0]          r_shift;
  logic [15:0]         r_length;
  logic [15:0]         r_mem_addr;
  logic [15:0]         r_byte_cnt;
  logic                r_busy;
  logic                r_done;

  logic w_accept;
  logic w_baud_last;
  logic w_lat_done;
  logic w_last_byte;
  logic w_serial;

  // A start landing on the done cycle is dropped; the host must re-pulse.
  assign w_accept    = (r_state == S_IDLE) && start && !r_done;
  assign w_baud_last = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_lat_done  = (r_lat == 2'(READ_LATENCY));
  assign w_last_byte = ((r_byte_cnt + 16'd1) == r_length);
  assign w_serial    = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_state_next and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = (length == 16'd0) ? S_FIN : S_FETCH;
      S_FETCH: w_state_next = S_WAIT;
      S_WAIT:  if (w_lat_done) w_state_next = S_START;
      S_START: if (w_baud_last) w_state_next = S_DATA;
      S_DATA:  if (w_baud_last && (r_bit == 3'd7)) w_state_next = S_STOP;
      S_STOP:  if (w_baud_last) w_state_next = w_last_byte ? S_FIN : S_FETCH;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_baud     <= '0;
      r_lat      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_length   <= '0;
      r_mem_addr <= '0;
      r_byte_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_baud <= (w_serial && !w_baud_last) ? r_baud + 1'b1 : '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_length   <= length;
            r_byte_cnt <= '0;
            r_busy     <= 1'b1;
            if (length != 16'd0) r_mem_addr <= base_addr;
          end
        end
        S_FETCH: r_lat <= '0;
        S_WAIT: begin
          // The extra WAIT cycle past READ_LATENCY gives the READ_LATENCY+2 inter-frame gap.
          if (w_lat_done) r_shift <= mem_q;
          else            r_lat   <= r_lat + 2'd1;
        end
        S_START: if (w_baud_last) r_bit <= '0;
        S_DATA: begin
          if (w_baud_last) begin
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 3'd1;
          end
        end
        S_STOP: begin
          if (w_baud_last) begin
            r_byte_cnt <= r_byte_cnt + 16'd1;
            if (!w_last_byte) r_mem_addr <= r_mem_addr + 16'd1;
          end
        end
        S_FIN: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // tx decodes straight from reset-cleared registers, so reset forces it high at once.
  assign tx       = (r_state == S_START) ? 1'b0 :
                    (r_state == S_DATA)  ? r_shift[0] : 1'b1;
  assign mem_addr = r_mem_addr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign byte_cnt = r_byte_cnt;

endmodule
